score_display_mux: RTL and testbench

//   Scanning seven-segment driver for the pong score. Consumes the BCD digit

---
 rtl/score_display_mux.sv | 134 +++++++++++++
 tb/tb_score_display_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// ---------------------------------------------------------------------------
// score_display_mux
//   Scanning seven-segment driver for the pong score on a 4-digit
//   common-anode display. The four BCD score digits are captured into
//   shadow registers once per scan frame so a frame never mixes old and
//   new scores. Adds leading-zero blanking of the tens digits, a dash for
//   non-BCD digits, a decimal point between the two scores and a
//   whole-display blink.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   p1_dig1    : player 1 tens digit (BCD)
//   p1_dig0    : player 1 units digit (BCD)
//   p2_dig1    : player 2 tens digit (BCD)
//   p2_dig0    : player 2 units digit (BCD)
//   blank_lz   : 1 = blank a zero tens digit
//   blink_en   : 1 = blink the whole display
//   an         : digit enables, active-low, an[3] leftmost
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse after a new snapshot is taken
// ---------------------------------------------------------------------------
module score_display_mux #(
    parameter int DWELL_BITS = 16,
    parameter int BLINK_BITS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p1_dig1,
    input  logic [3:0] p1_dig0,
    input  logic [3:0] p2_dig1,
    input  logic [3:0] p2_dig0,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    logic [DWELL_BITS-1:0] dwell_cnt;
    logic [1:0]            idx;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_ph;

    // Shadow slot n drives an[n]: 0=p2 units, 1=p2 tens, 2=p1 units, 3=p1 tens
    logic [3:0]            shadow [4];

    logic                  dwell_end;
    logic                  frame_end;
    logic [3:0]            cur_dig;
    logic                  tens_blank;
    logic [3:0]            an_p0;
    logic [6:0]            seg_p0;
    logic                  dp_p0;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;   // non-BCD: dash (segment g only)
        endcase
        return s;
    endfunction

    assign dwell_end = &dwell_cnt;
    // Last dwell cycle of the leftmost digit closes the frame
    assign frame_end = dwell_end && (idx == 2'd3);

    // Next registered output, computed from the current idx and shadow
    always_comb begin
        cur_dig    = shadow[idx];
        // Odd slots are tens digits; only an exact zero is blanked
        tens_blank = blank_lz && idx[0] && (cur_dig == 4'd0);
        an_p0      = 4'b1111;
        if (!tens_blank && !blink_ph) begin
            an_p0 = ~(4'b0001 << idx);
        end
        seg_p0     = decode(cur_dig);
        dp_p0      = !((idx == 2'd2) && !blink_ph);
    end

    // Output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt  <= '0;
            idx        <= 2'd0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'd0;
            end
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            dwell_cnt  <= dwell_cnt + DWELL_BITS'(1);
            if (dwell_end) begin
                idx <= idx + 2'd1;
            end
            frame_tick <= frame_end;
            if (frame_end) begin
                shadow[0] <= p2_dig0;
                shadow[1] <= p2_dig1;
                shadow[2] <= p1_dig0;
                shadow[3] <= p1_dig1;
            end
            if (blink_en) begin
                blink_cnt <= blink_cnt + BLINK_BITS'(1);
                if (&blink_cnt) begin
                    blink_ph <= ~blink_ph;
                end
            end else begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end
            an  <= an_p0;
            seg <= seg_p0;
            dp  <= dp_p0;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
module tb_score_display_mux;

    logic       clk;
    logic       reset;
    logic [3:0] p1_dig1;
    logic [3:0] p1_dig0;
    logic [3:0] p2_dig1;
    logic [3:0] p2_dig0;
    logic       blank_lz;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    logic [3:0] c_an  [48];
    logic [6:0] c_seg [48];
    logic       c_dp  [48];
    logic       c_ft  [48];

    score_display_mux #(.DWELL_BITS(2), .BLINK_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .p1_dig1    (p1_dig1),
        .p1_dig0    (p1_dig0),
        .p2_dig1    (p2_dig1),
        .p2_dig0    (p2_dig0),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge at which frame_tick is high
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        if (frame_tick !== 1'b1) chk("frame_tick_timeout", 32'(frame_tick), 32'd1);
    endtask

    // Record n consecutive cycles, sampled on the falling edge
    task automatic cap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_an[i]  = an;
            c_seg[i] = seg;
            c_dp[i]  = dp;
            c_ft[i]  = frame_tick;
        end
    endtask

    initial begin
        reset    = 1'b1;
        p1_dig1  = 4'd4;
        p1_dig0  = 4'd2;
        p2_dig1  = 4'd0;
        p2_dig0  = 4'd7;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_an",  32'(an),  32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp",  32'(dp),  32'd1);
        chk("rst_ft",  32'(frame_tick), 32'd0);

        // Test 1: scan order after release, shadow still zero
        reset = 1'b0;
        cap(16);
        chk("t1_an0", 32'(c_an[0]),  32'b1110);
        chk("t1_an0b", 32'(c_an[3]), 32'b1110);
        chk("t1_an1", 32'(c_an[4]),  32'b1101);
        chk("t1_an2", 32'(c_an[8]),  32'b1011);
        chk("t1_an3", 32'(c_an[12]), 32'b0111);
        chk("t1_seg0", 32'(c_seg[0]), 32'b1000000);
        chk("t1_dp2", 32'(c_dp[8]),  32'd0);
        chk("t1_dp3", 32'(c_dp[12]), 32'd1);
        chk("t1_ft_early", 32'(c_ft[14]), 32'd0);
        chk("t1_ft16", 32'(c_ft[15]), 32'd1);

        // Test 2: p1=42, p2=07 shown in the frame after the first snapshot
        cap(16);
        chk("t2_an0",  32'(c_an[0]),   32'b1110);
        chk("t2_seg0", 32'(c_seg[0]),  32'b1111000);
        chk("t2_seg1", 32'(c_seg[4]),  32'b1000000);
        chk("t2_an2",  32'(c_an[8]),   32'b1011);
        chk("t2_seg2", 32'(c_seg[8]),  32'b0100100);
        chk("t2_dp2",  32'(c_dp[8]),   32'd0);
        chk("t2_seg3", 32'(c_seg[12]), 32'b0011001);
        chk("t2_ft",   32'(c_ft[15]),  32'd1);

        // Test 3: mid-frame input change stays invisible until the snapshot
        repeat (5) @(negedge clk);
        chk("t3_an1", 32'(an), 32'b1101);
        p2_dig0 = 4'd3;
        p1_dig0 = 4'd9;
        repeat (4) @(negedge clk);
        chk("t3_old_seg2", 32'(seg), 32'b0100100);
        wait_tick();
        cap(16);
        chk("t3_seg0", 32'(c_seg[0]), 32'b0110000);
        chk("t3_seg2", 32'(c_seg[8]), 32'b0010000);

        // Test 4: leading-zero blanking, units zero still shown
        blank_lz = 1'b1;
        p1_dig1  = 4'd0;
        p1_dig0  = 4'd5;
        p2_dig1  = 4'd0;
        p2_dig0  = 4'd0;
        wait_tick();
        cap(16);
        for (int i = 0; i < 16; i++) begin
            chk("t4_an1_off", 32'(c_an[i][1]), 32'd1);
            chk("t4_an3_off", 32'(c_an[i][3]), 32'd1);
        end
        chk("t4_an1_all", 32'(c_an[4]),  32'b1111);
        chk("t4_dp1",     32'(c_dp[4]),  32'd1);
        chk("t4_an0",     32'(c_an[0]),  32'b1110);
        chk("t4_seg0",    32'(c_seg[0]), 32'b1000000);
        chk("t4_an2",     32'(c_an[8]),  32'b1011);
        chk("t4_seg2",    32'(c_seg[8]), 32'b0010010);

        // Test 5: non-BCD units and tens show a dash; tens >9 is not blanked
        p1_dig0 = 4'hC;
        p1_dig1 = 4'hA;
        wait_tick();
        cap(16);
        chk("t5_seg2", 32'(c_seg[8]),  32'b0111111);
        chk("t5_an3",  32'(c_an[12]),  32'b0111);
        chk("t5_seg3", 32'(c_seg[12]), 32'b0111111);
        chk("t5_an1",  32'(c_an[4]),   32'b1111);

        // Test 6: blink, then resume, then asynchronous reset during idx2
        blank_lz = 1'b0;
        p1_dig1  = 4'd1;
        p1_dig0  = 4'd2;
        p2_dig1  = 4'd3;
        p2_dig0  = 4'd4;
        wait_tick();
        blink_en = 1'b1;
        cap(48);
        for (int i = 0; i < 48; i++) begin
            if (i >= 16 && i < 32) begin
                chk("t6_dark_an", 32'(c_an[i]), 32'hF);
                chk("t6_dark_dp", 32'(c_dp[i]), 32'd1);
            end else begin
                chk("t6_scan_an", 32'(c_an[i] != 4'hF), 32'd1);
            end
        end
        chk("t6_scan_an0", 32'(c_an[32]), 32'b1110);
        chk("t6_ft_dark",  32'(c_ft[31]), 32'd1);
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_resume", 32'(an != 4'hF), 32'd1);

        wait_tick();
        repeat (9) @(negedge clk);
        chk("t6_pre_an2", 32'(an), 32'b1011);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_an",  32'(an),  32'hF);
        chk("t6_rst_seg", 32'(seg), 32'h7F);
        chk("t6_rst_dp",  32'(dp),  32'd1);
        repeat (3) @(negedge clk);
        chk("t6_rst_hold", 32'(an), 32'hF);
        blank_lz = 1'b1;
        reset    = 1'b0;
        cap(16);
        chk("t6_rel_an0",  32'(c_an[0]),  32'b1110);
        chk("t6_rel_seg0", 32'(c_seg[0]), 32'b1000000);
        chk("t6_rel_an1",  32'(c_an[4]),  32'b1111);
        chk("t6_rel_ft",   32'(c_ft[15]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
